tor_slot_sync_rx: RTL and testbench
===================================

# tor_slot_sync_rx

ToR-side receiver for the OCS controller's control channel. It parses control frames arriving from the ToR's control-link MAC, filters them by destination MAC and EtherType, and decodes the sim-start and time-sync commands. From those it keeps a local slot timebase: slot ID, slot-active window, reconfiguration guard window and an in-slot cycle counter. The VLB scheduler and the server traffic generators consume these outputs.

## Interface
Parameters:
- P_MY_TOR_MAC, 48'h8D_BC_5C_4A_00_00: this ToR's MAC address. Frames to it or to broadcast FF:FF:FF:FF:FF:FF are accepted.
- P_CTRL_ETH_TYPE, 16'hFF00: EtherType of control frames.
- P_SLOT_LEN, 32'h0000_0927: slot length in clock cycles (2343).
- P_CONFIG_DELAY, 32'h0000_00EA: OCS reconfiguration guard in cycles (234).
- P_SLOT_ID_W, 1: width of o_slot_id.

Ports:
- i_clk, in, 1: single clock (MAC RX user clock).
- i_rst_n, in, 1: reset. Asynchronous assertion, active-low.
- i_rx_axis_data, in, 64: frame data. Byte lane [63:56] is the first byte on the wire.
- i_rx_axis_keep, in, 8: byte enables. Ignored except on the last beat.
- i_rx_axis_valid, in, 1: beat valid. There is no backpressure; the block always accepts.
- i_rx_axis_last, in, 1: last beat of the frame.
- i_rx_axis_user, in, 1: frame error (FCS/PHY). Sampled on the last beat.
- o_sim_start, out, 1: sticky. Set by the first accepted SIM_START command.
- o_slot_id, out, P_SLOT_ID_W: current slot ID.
- o_slot_start, out, 1: one-cycle pulse when a slot begins.
- o_slot_end, out, 1: one-cycle pulse when the local slot counter expires.
- o_slot_active, out, 1: high while data transmission is permitted.
- o_guard, out, 1: high during the reconfiguration window.
- o_slot_cnt, out, 32: cycles elapsed since slot start.
- o_sync_lost, out, 1: sticky. Set when the guard window expires without a sync (see Configuration).
- o_drop_cnt, out, 16: count of rejected frames. Saturates at FFFF.

## Operation
Frame layout:
- Beat 0 = dst MAC[47:0] ‖ src MAC[47:32].
- Beat 1 = src MAC[31:0] ‖ EtherType[15:0] ‖ CMD[7:0] ‖ SLOT_ID[7:0].
- Later beats (padding up to 64 B) are ignored until last.
- CMD encoding: 8'h01 = SIM_START, 8'h02 = TIME_SYNC. Any other value means the frame is dropped.

Parser:
- A beat counter (saturates at 2) tracks position in the frame.
- dst_ok, type_ok and the CMD/SLOT_ID fields are latched at beats 0 and 1.
- Commit happens on the valid && last beat when all of these hold: beat count ≥ 1 (at least 2 beats), dst_ok, type_ok, known CMD, user == 0.
- Otherwise the frame is dropped and o_drop_cnt increments, including frames that end at beat 0.

Commands on commit:
- SIM_START: o_sim_start <= 1. No effect on the timebase.
- TIME_SYNC:
  - o_slot_id <= SLOT_ID[P_SLOT_ID_W-1:0]
  - o_slot_cnt <= 0
  - pulse o_slot_start
  - state goes to ACTIVE from any state
  - also sets o_sim_start

Timebase state machine:
- IDLE: after reset. Outputs low. Waits for TIME_SYNC.
- ACTIVE: o_slot_active = 1 and o_slot_cnt increments every cycle. When o_slot_cnt == P_SLOT_LEN-1: pulse o_slot_end, clear the guard counter, go to GUARD.
- GUARD: o_guard = 1 and o_slot_cnt holds. The guard counter increments. TIME_SYNC goes to ACTIVE. Expiry is handled per Configuration.

Boundary conditions:
- Sync commit in the same cycle as the ACTIVE expiry: sync wins. Counter restarts, no o_slot_end pulse, no GUARD.
- Sync during ACTIVE mid-slot: immediate resync, counter restarts at 0.
- Slot ID arithmetic is modulo 2^P_SLOT_ID_W (wraps).
- Reset mid-frame or mid-slot: parser returns to beat 0, all state is cleared, and the partial frame is not counted as a drop.

## Timing
- All outputs are registered. Reset value of every output is 0, state is IDLE.
- Commit latency: the last beat at cycle N updates o_slot_id, o_slot_cnt = 0, o_slot_start = 1 and o_slot_active = 1 at cycle N+1.
- o_slot_cnt reads 0 in the first active cycle and P_SLOT_LEN-1 in the last.
- o_slot_end rises in the cycle after o_slot_cnt == P_SLOT_LEN-1, together with o_guard = 1.
- o_drop_cnt updates at N+1.
- Back-to-back frames (last followed directly by a new beat 0) are fully supported.

## Configuration
- SLOT_FREERUN_EN defined: when the guard counter reaches P_CONFIG_DELAY-1 with no sync, the block free-runs into the next slot:
  - o_slot_id increments (wraps)
  - o_slot_cnt resets to 0
  - pulse o_slot_start
  - set o_sync_lost
  - go to ACTIVE
- SLOT_FREERUN_EN undefined: GUARD persists indefinitely until TIME_SYNC arrives. o_sync_lost is tied to 0 and the guard counter is not synthesised.

## Test plan
- Reset, then TIME_SYNC broadcast frame with SLOT_ID = 1 (4 beats, last keep = 8'hFF) → at N+1: o_slot_id = 1, o_slot_start pulse, o_sim_start = 1, o_slot_active = 1; o_slot_end 2343 cycles later; o_guard = 1.
- Frame with dst = 8D:BC:5C:4A:05:00, or EtherType 0x0800, or user = 1 on the last beat, or CMD = 0x07 → no timebase change; o_drop_cnt increments by 1 per frame.
- Sync arriving exactly on the o_slot_cnt == 2342 cycle → no o_slot_end, o_slot_cnt = 0 next cycle, o_guard stays 0.
- With SLOT_FREERUN_EN and no sync after slot end with o_slot_id = 1: after 234 guard cycles → o_slot_id = 0, o_sync_lost = 1, o_slot_start pulse. Without the macro: o_guard held for 10000 cycles.
- i_rst_n asserted mid-frame at beat 1, then released, then a valid sync sent → all outputs 0 during reset; the following frame is accepted normally and o_drop_cnt = 0.
- SIM_START frame to P_MY_TOR_MAC → o_sim_start = 1 while o_slot_active stays 0 (state IDLE).

Source files
------------

// File: rtl/tor_slot_sync_rx.sv
// rtl/tor_slot_sync_rx.sv - ToR control-frame receiver and local slot timebase
// Optional feature: SLOT_FREERUN_EN. When defined, an expired guard window with
// no sync free-runs into the next slot. When undefined, GUARD holds until a sync.
// Ports:
//   i_clk, i_rst_n            clock, async active-low reset
//   i_rx_axis_data/keep/valid/last/user   control-link MAC RX stream (no backpressure)
//   o_sim_start               sticky, first accepted SIM_START or TIME_SYNC
//   o_slot_id                 current slot ID
//   o_slot_start/o_slot_end   one-cycle slot boundary pulses
//   o_slot_active/o_guard     transmit window / reconfiguration window
//   o_slot_cnt                cycles since slot start
//   o_sync_lost               sticky, guard expired without sync (free-run build only)
//   o_drop_cnt                saturating count of rejected frames
module tor_slot_sync_rx #(
    parameter logic [47:0] P_MY_TOR_MAC    = 48'h8DBC5C4A0000,
    parameter logic [15:0] P_CTRL_ETH_TYPE = 16'hFF00,
    parameter logic [31:0] P_SLOT_LEN      = 32'h0000_0927,
    parameter logic [31:0] P_CONFIG_DELAY  = 32'h0000_00EA,
    parameter int          P_SLOT_ID_W     = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [63:0]            i_rx_axis_data,
    input  logic [7:0]             i_rx_axis_keep,
    input  logic                   i_rx_axis_valid,
    input  logic                   i_rx_axis_last,
    input  logic                   i_rx_axis_user,
    output logic                   o_sim_start,
    output logic [P_SLOT_ID_W-1:0] o_slot_id,
    output logic                   o_slot_start,
    output logic                   o_slot_end,
    output logic                   o_slot_active,
    output logic                   o_guard,
    output logic [31:0]            o_slot_cnt,
    output logic                   o_sync_lost,
    output logic [15:0]            o_drop_cnt
);

    localparam logic [47:0] LP_BCAST     = 48'hFFFF_FFFF_FFFF;
    localparam logic [7:0]  LP_CMD_START = 8'h01;
    localparam logic [7:0]  LP_CMD_SYNC  = 8'h02;

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GUARD} state_t;

    // ---------------- parser ----------------
    logic [1:0] r_beat;
    logic       r_dst_ok;
    logic       r_type_ok;
    logic [7:0] r_cmd;
    logic [7:0] r_slot;

    logic       w_beat0_dst_ok;
    logic       w_type_ok;
    logic [7:0] w_cmd;
    logic [7:0] w_slot;
    logic       w_eof;
    logic       w_commit;
    logic       w_sync;
    logic       w_drop;

    assign w_beat0_dst_ok = (i_rx_axis_data[63:16] == P_MY_TOR_MAC) ||
                            (i_rx_axis_data[63:16] == LP_BCAST);

    // A frame may end on beat 1, so the header fields are taken straight from
    // the bus on that beat instead of from the latches filled one cycle later.
    assign w_type_ok = (r_beat == 2'd1) ? (i_rx_axis_data[31:16] == P_CTRL_ETH_TYPE) : r_type_ok;
    assign w_cmd     = (r_beat == 2'd1) ? i_rx_axis_data[15:8] : r_cmd;
    assign w_slot    = (r_beat == 2'd1) ? i_rx_axis_data[7:0]  : r_slot;

    assign w_eof    = i_rx_axis_valid && i_rx_axis_last;
    assign w_commit = w_eof && (r_beat != 2'd0) && r_dst_ok && w_type_ok &&
                      ((w_cmd == LP_CMD_START) || (w_cmd == LP_CMD_SYNC)) && !i_rx_axis_user;
    assign w_sync   = w_commit && (w_cmd == LP_CMD_SYNC);
    assign w_drop   = w_eof && !w_commit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_beat      <= 2'd0;
            r_dst_ok    <= 1'b0;
            r_type_ok   <= 1'b0;
            r_cmd       <= 8'd0;
            r_slot      <= 8'd0;
            o_drop_cnt  <= 16'd0;
            o_sim_start <= 1'b0;
        end else begin
            if (i_rx_axis_valid) begin
                if (i_rx_axis_last)
                    r_beat <= 2'd0;
                else if (r_beat != 2'd2)
                    r_beat <= r_beat + 2'd1;
                if (r_beat == 2'd0)
                    r_dst_ok <= w_beat0_dst_ok;
                if (r_beat == 2'd1) begin
                    r_type_ok <= w_type_ok;
                    r_cmd     <= w_cmd;
                    r_slot    <= w_slot;
                end
            end
            if (w_drop && (o_drop_cnt != 16'hFFFF))
                o_drop_cnt <= o_drop_cnt + 16'd1;
            if (w_commit)
                o_sim_start <= 1'b1;
        end
    end

    // ---------------- timebase FSM ----------------
    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [31:0]              w_cnt_nxt;
    logic [P_SLOT_ID_W-1:0]   w_id_nxt;
    logic                     w_start_nxt;
    logic                     w_end_nxt;

`ifdef SLOT_FREERUN_EN
    logic [31:0] r_guard_cnt;
    logic [31:0] w_gcnt_nxt;
    logic        r_sync_lost;
    logic        w_lost_nxt;

    assign o_sync_lost = r_sync_lost;
`else
    assign o_sync_lost = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = o_slot_cnt;
        w_id_nxt    = o_slot_id;
        w_start_nxt = 1'b0;
        w_end_nxt   = 1'b0;
`ifdef SLOT_FREERUN_EN
        w_gcnt_nxt  = r_guard_cnt;
        w_lost_nxt  = r_sync_lost;
`endif
        // A sync overrides whatever the local timebase would do this cycle,
        // including a coincident slot expiry or guard expiry.
        if (w_sync) begin
            w_state_nxt = S_ACTIVE;
            w_cnt_nxt   = 32'd0;
            w_id_nxt    = w_slot[P_SLOT_ID_W-1:0];
            w_start_nxt = 1'b1;
        end else begin
            case (r_state)
                S_ACTIVE: begin
                    if (o_slot_cnt == P_SLOT_LEN - 32'd1) begin
                        w_end_nxt   = 1'b1;
                        w_state_nxt = S_GUARD;
`ifdef SLOT_FREERUN_EN
                        w_gcnt_nxt  = 32'd0;
`endif
                    end else begin
                        w_cnt_nxt = o_slot_cnt + 32'd1;
                    end
                end
`ifdef SLOT_FREERUN_EN
                S_GUARD: begin
                    if (r_guard_cnt == P_CONFIG_DELAY - 32'd1) begin
                        w_state_nxt = S_ACTIVE;
                        w_cnt_nxt   = 32'd0;
                        w_id_nxt    = o_slot_id + P_SLOT_ID_W'(1);
                        w_start_nxt = 1'b1;
                        w_lost_nxt  = 1'b1;
                    end else begin
                        w_gcnt_nxt = r_guard_cnt + 32'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            o_slot_cnt    <= 32'd0;
            o_slot_id     <= '0;
            o_slot_start  <= 1'b0;
            o_slot_end    <= 1'b0;
            o_slot_active <= 1'b0;
            o_guard       <= 1'b0;
`ifdef SLOT_FREERUN_EN
            r_guard_cnt   <= 32'd0;
            r_sync_lost   <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_nxt;
            o_slot_cnt    <= w_cnt_nxt;
            o_slot_id     <= w_id_nxt;
            o_slot_start  <= w_start_nxt;
            o_slot_end    <= w_end_nxt;
            o_slot_active <= (w_state_nxt == S_ACTIVE);
            o_guard       <= (w_state_nxt == S_GUARD);
`ifdef SLOT_FREERUN_EN
            r_guard_cnt   <= w_gcnt_nxt;
            r_sync_lost   <= w_lost_nxt;
`endif
        end
    end

    // Control content lives entirely in beats 0 and 1, so byte enables never
    // influence decoding, and only the low slot-ID bits reach o_slot_id.
    logic w_unused;
`ifdef SLOT_FREERUN_EN
    assign w_unused = ^{i_rx_axis_keep, w_slot};
`else
    assign w_unused = ^{i_rx_axis_keep, w_slot, P_CONFIG_DELAY};
`endif

endmodule

// File: tb/tb_tor_slot_sync_rx.sv
// tb/tb_tor_slot_sync_rx.sv - randomized self-checking bench for tor_slot_sync_rx
module tb_tor_slot_sync_rx;

    localparam longint     LEN   = 2343;
    localparam longint     DLY   = 234;
    localparam logic [47:0] MY   = 48'h8DBC5C4A0000;
    localparam logic [47:0] BC   = 48'hFFFFFFFFFFFF;
    localparam logic [15:0] ETH  = 16'hFF00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] data = '0;
    logic [7:0]  keep = '0;
    logic        valid = 1'b0;
    logic        last = 1'b0;
    logic        user = 1'b0;

    logic        o_sim_start;
    logic [0:0]  o_slot_id;
    logic        o_slot_start;
    logic        o_slot_end;
    logic        o_slot_active;
    logic        o_guard;
    logic [31:0] o_slot_cnt;
    logic        o_sync_lost;
    logic [15:0] o_drop_cnt;

    tor_slot_sync_rx dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_rx_axis_data(data), .i_rx_axis_keep(keep), .i_rx_axis_valid(valid),
        .i_rx_axis_last(last), .i_rx_axis_user(user),
        .o_sim_start(o_sim_start), .o_slot_id(o_slot_id), .o_slot_start(o_slot_start),
        .o_slot_end(o_slot_end), .o_slot_active(o_slot_active), .o_guard(o_guard),
        .o_slot_cnt(o_slot_cnt), .o_sync_lost(o_sync_lost), .o_drop_cnt(o_drop_cnt)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        longint     t;
        bit         drop;
        bit         sim;
        bit         sync;
        logic [7:0] slot;
    } ev_t;

    ev_t    evq[$];
    bit     mon_en   = 1'b0;
    bit     m_started;
    bit     m_sim;
    bit     m_lost;
    longint m_sync_t;
    longint m_base;
    int     m_drop;

    task automatic model_clear();
        m_started = 1'b0; m_sim = 1'b0; m_lost = 1'b0;
        m_sync_t = 0; m_base = 0; m_drop = 0;
        evq.delete();
    endtask

    // Number of whole slot+guard periods elapsed since the last sync (free-run only).
    function automatic longint periods(longint t);
`ifdef SLOT_FREERUN_EN
        if (!m_started || t < m_sync_t) return 0;
        return (t - m_sync_t) / (LEN + DLY);
`else
        return 0;
`endif
    endfunction

    always @(negedge clk) begin
        longint e, k, r;
        logic [31:0] x_cnt, x_id;
        bit x_act, x_grd, x_st, x_en, x_lost;
        ev_t ev;
        if (mon_en) begin
            while (evq.size() > 0 && evq[0].t <= cyc) begin
                ev = evq.pop_front();
                if (ev.drop && m_drop < 65535) m_drop++;
                if (ev.sim) m_sim = 1'b1;
                if (ev.sync) begin
                    m_lost    = m_lost || (periods(cyc - 1) > 0);
                    m_started = 1'b1;
                    m_sync_t  = cyc;
                    m_base    = ev.slot % 2;
                end
            end
            x_cnt = 0; x_id = 0; x_act = 0; x_grd = 0; x_st = 0; x_en = 0; x_lost = m_lost;
            if (m_started) begin
                e = cyc - m_sync_t;
                k = periods(cyc);
`ifdef SLOT_FREERUN_EN
                r = e % (LEN + DLY);
`else
                r = e;
`endif
                x_id   = 32'((m_base + k) % 2);
                x_lost = m_lost || (k > 0);
                if (r < LEN) begin
                    x_act = 1; x_cnt = 32'(r); x_st = (r == 0);
                end else begin
                    x_grd = 1; x_cnt = 32'(LEN - 1); x_en = (r == LEN);
                end
            end
            check("slot_id",     32'(o_slot_id),     x_id);
            check("slot_cnt",    o_slot_cnt,         x_cnt);
            check("slot_active", 32'(o_slot_active), 32'(x_act));
            check("guard",       32'(o_guard),       32'(x_grd));
            check("slot_start",  32'(o_slot_start),  32'(x_st));
            check("slot_end",    32'(o_slot_end),    32'(x_en));
            check("sim_start",   32'(o_sim_start),   32'(m_sim));
            check("sync_lost",   32'(o_sync_lost),   32'(x_lost));
            check("drop_cnt",    32'(o_drop_cnt),    32'(m_drop));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            valid = 1'b0; last = 1'b0; user = 1'b0;
            data = {$urandom, $urandom};
        end
    endtask

    task automatic wait_until(input longint c);
        while (cyc < c) idle(1);
    endtask

    task automatic do_reset(input int n);
        tick();
        rst_n = 1'b0; valid = 1'b0; last = 1'b0; user = 1'b0;
        model_clear();
        repeat (n) tick();
        rst_n = 1'b1;
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] typ, input logic [7:0] cmd,
                              input logic [7:0] slot, input int nb, input bit usr);
        bit acc;
        ev_t ev;
        for (int i = 0; i < nb; i++) begin
            tick();
            valid = 1'b1;
            last  = (i == nb - 1);
            keep  = last ? 8'hFF : 8'($urandom);
            user  = last ? usr : 1'($urandom);
            if (i == 0)      data = {dst, src[47:32]};
            else if (i == 1) data = {src[31:0], typ, cmd, slot};
            else             data = {$urandom, $urandom};
        end
        acc = (nb >= 2) && (dst == MY || dst == BC) && (typ == ETH) &&
              (cmd == 8'h01 || cmd == 8'h02) && !usr;
        ev.t = cyc + 1; ev.drop = !acc; ev.sim = acc;
        ev.sync = acc && (cmd == 8'h02); ev.slot = slot;
        evq.push_back(ev);
    endtask

    task automatic send_sync(input logic [47:0] dst, input logic [7:0] slot, input int nb);
        send_frame(dst, 48'h001122334455, ETH, 8'h02, slot, nb, 1'b0);
    endtask

    task automatic random_frame();
        logic [63:0] rnd;
        logic [47:0] dst;
        logic [15:0] typ;
        logic [7:0]  cmd;
        int nb;
        rnd = {$urandom, $urandom};
        case ($urandom % 4)
            0:       dst = MY;
            1:       dst = BC;
            2:       dst = MY ^ (48'd1 << $urandom_range(47, 0));
            default: dst = rnd[47:0];
        endcase
        typ = ($urandom % 5 != 0) ? ETH : (($urandom % 2 != 0) ? 16'h0800 : 16'($urandom));
        case ($urandom % 8)
            0, 1, 2: cmd = 8'h02;
            3, 4:    cmd = 8'h01;
            5:       cmd = 8'h07;
            6:       cmd = 8'h00;
            default: cmd = 8'($urandom);
        endcase
        nb = ($urandom % 10 == 0) ? 1 : $urandom_range(8, 2);
        send_frame(dst, rnd[63:16], typ, cmd, 8'($urandom), nb, ($urandom % 8 == 0));
    endtask

    initial begin
        model_clear();
        tick();
        mon_en = 1'b1;
        do_reset(3);
        idle(5);

        // SIM_START to this ToR: sim_start without timebase activity
        send_frame(MY, 48'h0A0B0C0D0E0F, ETH, 8'h01, 8'h00, 4, 1'b0);
        idle(5);

        // rejected frames, one drop each
        send_frame(48'h8DBC5C4A0500, 48'h1, ETH,      8'h02, 8'h01, 4, 1'b0);
        idle(2);
        send_frame(BC,               48'h1, 16'h0800, 8'h02, 8'h01, 4, 1'b0);
        idle(2);
        send_frame(BC,               48'h1, ETH,      8'h02, 8'h01, 4, 1'b1);
        idle(2);
        send_frame(MY,               48'h1, ETH,      8'h07, 8'h01, 4, 1'b0);
        send_frame(MY,               48'h1, ETH,      8'h02, 8'h01, 1, 1'b0);
        idle(5);

        // broadcast TIME_SYNC slot 1, run through slot end and into guard
        send_sync(BC, 8'h01, 4);
        idle(int'(LEN) + 50);

        // sync landing exactly on the last active cycle
        send_sync(MY, 8'h00, 2);
        idle(10);
        wait_until(m_sync_t + LEN - 3);
        send_sync(MY, 8'h01, 2);
        idle(20);

        // mid-slot resync
        idle(100);
        send_sync(BC, 8'h03, 3);
        idle(30);

        // no further sync: guard hold (or free-run) for a long stretch
        send_sync(MY, 8'h01, 2);
        idle(int'(LEN) + 10000);

        // reset in the middle of a frame, then a clean sync
        tick();
        valid = 1'b1; last = 1'b0; data = {BC, 16'h0011};
        tick();
        data = {32'h22334455, ETH, 8'h02, 8'h01};
        do_reset(4);
        idle(3);
        send_sync(BC, 8'h01, 4);
        idle(10);

        // randomized traffic, back-to-back and with long quiet gaps
        for (int f = 0; f < 300; f++) begin
            random_frame();
            if ($urandom % 25 == 0) idle($urandom_range(3000, 2000));
            else                    idle($urandom_range(3, 0));
        end
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
